if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage_pkg.sv | 18 +
 rtl/sat_counter.sv | 38 +++
 rtl/if_id_stage.sv | 121 ++++++++++++
 tb/tb_if_id_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions: IF/ID control state encoding, the NOP word
// injected on a squash, and the register-match helper used by hazard detection.
package if_id_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } id_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // True when register r is one of the instruction's source fields (rs or rt).
    function automatic logic reads_reg(input logic [31:0] instr, input logic [4:0] r);
        return (r == instr[25:21]) || (r == instr[20:16]);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next value: step on inc unless already pinned at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != MAX)) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch flush and
// saturating stall/flush performance counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction_IF,
    input  logic [31:0]      PC_sumado_IF,
    input  logic             MemRead_EX,
    input  logic [4:0]       rt_EX,
    input  logic             flush_req,
    output logic [31:0]      instruction_ID,
    output logic [31:0]      PC_sumado_ID,
    output logic             valid_ID,
    output logic             PC_write,
    output logic             bubble_ID,
    output logic [1:0]       state_ID,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    id_state_e   state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        hazard_s;
    logic        stall_s;

    // A squashed slot never matches, so a NOP after a flush cannot stall.
    assign hazard_s = MemRead_EX & valid_q & (rt_EX != 5'd0) & reads_reg(instr_q, rt_EX);
    assign stall_s  = hazard_s & ~flush_req;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush dominates stall, stall dominates run.
    always_comb begin
        state_d = ST_RUN;
        if (flush_req) begin
            state_d = ST_FLUSH;
        end else if (hazard_s) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    // FSM outputs: freeze fetch only on a stall; a flush lets the PC take the target.
    always_comb begin
        PC_write  = 1'b1;
        bubble_ID = hazard_s | flush_req;
        if (stall_s) begin
            PC_write = 1'b0;
        end else begin
            PC_write = 1'b1;
        end
    end

    assign state_ID = state_q;

    // Pipeline register next value: squash, hold, or advance.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_req) begin
            instr_d = NOP_INSTR;
            pc_d    = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (hazard_s) begin
            instr_d = instr_q;
            pc_d    = pc_q;
            valid_d = valid_q;
        end else begin
            instr_d = instruction_IF;
            pc_d    = PC_sumado_IF;
            valid_d = 1'b1;
        end
    end

    // IF/ID pipeline register; reset discards any held instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instruction_ID = instr_q;
    assign PC_sumado_ID   = pc_q;
    assign valid_ID       = valid_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_s),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_req),
        .count (flush_count)
    );

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a rule-level reference model checked every
// cycle, plus literal expectations on a default and a 2-bit-counter instance.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction_IF = 32'h0;
    logic [31:0] PC_sumado_IF = 32'h0;
    logic        MemRead_EX = 1'b0;
    logic [4:0]  rt_EX = 5'd0;
    logic        flush_req = 1'b0;

    logic [31:0] a_instr, a_pc, b_instr, b_pc;
    logic        a_valid, a_pcw, a_bub, b_valid, b_pcw, b_bub;
    logic [1:0]  a_state, b_state;
    logic [15:0] a_sc, a_fc;
    logic [1:0]  b_sc, b_fc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_id_stage dut_a (
        .clk(clk), .rst(rst), .instruction_IF(instruction_IF), .PC_sumado_IF(PC_sumado_IF),
        .MemRead_EX(MemRead_EX), .rt_EX(rt_EX), .flush_req(flush_req),
        .instruction_ID(a_instr), .PC_sumado_ID(a_pc), .valid_ID(a_valid), .PC_write(a_pcw),
        .bubble_ID(a_bub), .state_ID(a_state), .stall_count(a_sc), .flush_count(a_fc)
    );

    if_id_stage #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .instruction_IF(instruction_IF), .PC_sumado_IF(PC_sumado_IF),
        .MemRead_EX(MemRead_EX), .rt_EX(rt_EX), .flush_req(flush_req),
        .instruction_ID(b_instr), .PC_sumado_ID(b_pc), .valid_ID(b_valid), .PC_write(b_pcw),
        .bubble_ID(b_bub), .state_ID(b_state), .stall_count(b_sc), .flush_count(b_fc)
    );

    // Reference model: what ID should hold, plus raw (unbounded) event totals.
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc = 32'h0;
    logic        m_valid = 1'b0;
    int          m_state = 0;
    int          m_stalls = 0;
    int          m_flushes = 0;

    function automatic bit m_hazard();
        return MemRead_EX && m_valid && (rt_EX != 5'd0) &&
               ((rt_EX == m_instr[25:21]) || (rt_EX == m_instr[20:16]));
    endfunction

    function automatic int sat(input int raw, input int maxv);
        return (raw > maxv) ? maxv : raw;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_instr <= 32'h0; m_pc <= 32'h0; m_valid <= 1'b0; m_state <= 0;
            m_stalls <= 0; m_flushes <= 0;
        end else if (flush_req) begin
            m_instr <= 32'h0; m_pc <= 32'h0; m_valid <= 1'b0; m_state <= 2;
            m_flushes <= m_flushes + 1;
        end else if (m_hazard()) begin
            m_state <= 1;
            m_stalls <= m_stalls + 1;
        end else begin
            m_instr <= instruction_IF; m_pc <= PC_sumado_IF; m_valid <= 1'b1; m_state <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        bit h;
        h = m_hazard();
        chk("a_instr", a_instr, m_instr);
        chk("a_pc", a_pc, m_pc);
        chk("a_valid", {31'b0, a_valid}, {31'b0, m_valid});
        chk("a_state", {30'b0, a_state}, m_state);
        chk("a_pcw", {31'b0, a_pcw}, {31'b0, !(h && !flush_req)});
        chk("a_bub", {31'b0, a_bub}, {31'b0, h || flush_req});
        chk("a_sc", {16'b0, a_sc}, sat(m_stalls, 65535));
        chk("a_fc", {16'b0, a_fc}, sat(m_flushes, 65535));
        chk("b_instr", b_instr, m_instr);
        chk("b_valid", {31'b0, b_valid}, {31'b0, m_valid});
        chk("b_pc", b_pc, m_pc);
        chk("b_state", {30'b0, b_state}, m_state);
        chk("b_pcw", {31'b0, b_pcw}, {31'b0, !(h && !flush_req)});
        chk("b_bub", {31'b0, b_bub}, {31'b0, h || flush_req});
        chk("b_sc", {30'b0, b_sc}, sat(m_stalls, 3));
        chk("b_fc", {30'b0, b_fc}, sat(m_flushes, 3));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] ins, input logic [31:0] pc,
                          input logic mr, input logic [4:0] rt, input logic fl);
        instruction_IF = ins; PC_sumado_IF = pc; MemRead_EX = mr; rt_EX = rt; flush_req = fl;
    endtask

    initial begin
        rst = 1'b1;
        #7;
        chk("rst_instr", a_instr, 32'h0);
        chk("rst_valid", {31'b0, a_valid}, 32'd0);
        chk("rst_state", {30'b0, a_state}, 32'd0);
        chk("rst_sc", {16'b0, a_sc}, 32'd0);
        chk("rst_pcw", {31'b0, a_pcw}, 32'd1);
        chk("rst_bub0", {31'b0, a_bub}, 32'd0);
        flush_req = 1'b1;
        #1;
        chk("rst_bub_flush", {31'b0, a_bub}, 32'd1);
        chk("rst_pcw_flush", {31'b0, a_pcw}, 32'd1);
        flush_req = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Straight flow
        set_in(32'h8C220004, 32'd4, 1'b0, 5'd0, 1'b0);
        #1;
        chk("flow_pcw", {31'b0, a_pcw}, 32'd1);
        chk("flow_bub", {31'b0, a_bub}, 32'd0);
        tick();
        chk("flow_instr1", a_instr, 32'h8C220004);
        chk("flow_valid1", {31'b0, a_valid}, 32'd1);
        set_in(32'h00431020, 32'd8, 1'b0, 5'd0, 1'b0);
        tick();
        chk("flow_instr2", a_instr, 32'h00431020);
        chk("flow_pc2", a_pc, 32'd8);

        // Load-use on rt=3
        set_in(32'hAAAA0001, 32'd12, 1'b1, 5'd3, 1'b0);
        #1;
        chk("lu_pcw", {31'b0, a_pcw}, 32'd0);
        chk("lu_bub", {31'b0, a_bub}, 32'd1);
        tick();
        chk("lu_hold", a_instr, 32'h00431020);
        chk("lu_state", {30'b0, a_state}, 32'd1);
        chk("lu_sc", {16'b0, a_sc}, 32'd1);
        chk("model_sc", m_stalls, 32'd1);
        MemRead_EX = 1'b0;
        #1;
        chk("lu_release_pcw", {31'b0, a_pcw}, 32'd1);
        tick();
        chk("lu_resume", a_instr, 32'hAAAA0001);
        chk("lu_run", {30'b0, a_state}, 32'd0);

        // rt_EX = 0 never stalls
        set_in(32'h00001020, 32'd16, 1'b0, 5'd0, 1'b0);
        tick();
        set_in(32'h20420001, 32'd20, 1'b1, 5'd0, 1'b0);
        #1;
        chk("r0_pcw", {31'b0, a_pcw}, 32'd1);
        chk("r0_bub", {31'b0, a_bub}, 32'd0);
        tick();
        chk("r0_instr", a_instr, 32'h20420001);
        chk("r0_sc", {16'b0, a_sc}, 32'd1);

        // Hazard and flush together
        set_in(32'h11111111, 32'd24, 1'b1, 5'd2, 1'b1);
        #1;
        chk("hf_pcw", {31'b0, a_pcw}, 32'd1);
        chk("hf_bub", {31'b0, a_bub}, 32'd1);
        tick();
        chk("hf_instr", a_instr, 32'h0);
        chk("hf_valid", {31'b0, a_valid}, 32'd0);
        chk("hf_state", {30'b0, a_state}, 32'd2);
        chk("hf_fc", {16'b0, a_fc}, 32'd1);
        chk("hf_sc", {16'b0, a_sc}, 32'd1);
        set_in(32'h22222222, 32'd28, 1'b0, 5'd0, 1'b0);
        tick();
        chk("post_flush", a_instr, 32'h22222222);

        // Five stall cycles; the 2-bit counter pins at 3
        set_in(32'h44444444, 32'd32, 1'b1, 5'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_hold", a_instr, 32'h22222222);
        end
        chk("sat_b_sc", {30'b0, b_sc}, 32'd3);
        chk("sat_a_sc", {16'b0, a_sc}, 32'd6);
        MemRead_EX = 1'b0;
        tick();
        chk("sat_resume", a_instr, 32'h44444444);

        // Asynchronous reset in the middle of a stall
        MemRead_EX = 1'b1; rt_EX = 5'd2;
        tick();
        chk("ar_stall", {30'b0, a_state}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_instr", a_instr, 32'h0);
        chk("ar_valid", {31'b0, a_valid}, 32'd0);
        chk("ar_state", {30'b0, a_state}, 32'd0);
        chk("ar_sc", {16'b0, a_sc}, 32'd0);
        chk("ar_pcw", {31'b0, a_pcw}, 32'd1);
        set_in(32'h33333333, 32'd40, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("ar_load", a_instr, 32'h33333333);
        chk("ar_load_valid", {31'b0, a_valid}, 32'd1);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
